// File: rtl/flags_pkg.sv
// Shared flag indices, opcode constants and the per-opcode flag update mask.
package flags_pkg;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_S = 2;
    localparam int unsigned FLAG_O = 3;

    localparam int unsigned MASK_W = 4;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_ADC    = 5'b00001;
    localparam logic [4:0] OP_SUB    = 5'b00011;
    localparam logic [4:0] OP_NEG    = 5'b00110;
    localparam logic [4:0] OP_SHL    = 5'b01000;
    localparam logic [4:0] OP_SHR    = 5'b01001;
    localparam logic [4:0] OP_TST    = 5'b10000;
    localparam logic [4:0] OP_LOG_LO = 5'b10001;
    localparam logic [4:0] OP_LOG_HI = 5'b11110;

    localparam logic [MASK_W-1:0] MASK_ZCSO = 4'b1111;
    localparam logic [MASK_W-1:0] MASK_ZCS  = 4'b0111;
    localparam logic [MASK_W-1:0] MASK_ZS   = 4'b0101;
    localparam logic [MASK_W-1:0] MASK_Z    = 4'b0001;
    localparam logic [MASK_W-1:0] MASK_NONE = 4'b0000;

    function automatic logic [MASK_W-1:0] flag_mask(input logic [4:0] op);
        logic [MASK_W-1:0] m;
        m = MASK_NONE;
        if (op == OP_ADD || op == OP_ADC || (op >= OP_SUB && op <= OP_NEG)) begin
            m = MASK_ZCSO;
        end else if (op == OP_SHL || op == OP_SHR) begin
            m = MASK_ZCS;
        end else if (op == OP_TST) begin
            m = MASK_Z;
        end else if (op >= OP_LOG_LO && op <= OP_LOG_HI) begin
            m = MASK_ZS;
        end
        return m;
    endfunction

endpackage

// File: rtl/flags_ctx_stack.sv
// Context stack for flag save/restore: DEPTH x NFLAGS storage with push, pop and swap.
module flags_ctx_stack #(
    parameter int unsigned NFLAGS = 4,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [NFLAGS-1:0] wdata_i,
    output logic [NFLAGS-1:0] rdata_o,
    output logic              pop_ok_o,
    output logic [CNT_W-1:0]  depth_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              err_o
);

    logic [NFLAGS-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  depth_q, depth_d;
    logic              err_q, err_d;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [AW-1:0]     top_idx;

    assign full_o   = (depth_q == CNT_W'(DEPTH));
    assign empty_o  = (depth_q == '0);
    assign depth_o  = depth_q;
    assign err_o    = err_q;
    // Only meaningful when not empty; consumers gate it with pop_ok_o.
    assign top_idx  = AW'(depth_q - CNT_W'(1));
    assign rdata_o  = mem_q[top_idx];

    always_comb begin
        depth_d  = depth_q;
        err_d    = err_q;
        we       = 1'b0;
        waddr    = AW'(depth_q);
        pop_ok_o = 1'b0;
        if (push_i && pop_i) begin
            if (!empty_o) begin
                we       = 1'b1;
                waddr    = top_idx;
                pop_ok_o = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (push_i) begin
            if (!full_o) begin
                we      = 1'b1;
                depth_d = depth_q + CNT_W'(1);
            end else begin
                err_d = 1'b1;
            end
        end else if (pop_i) begin
            if (!empty_o) begin
                pop_ok_o = 1'b1;
                depth_d  = depth_q - CNT_W'(1);
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset; a write racing reset is dropped.
    always_ff @(posedge clk_i) begin
        if (we && !reset_i) begin
            mem_q[waddr] <= wdata_i;
        end
    end

endmodule

// File: rtl/flags_ctx_register.sv
// Processor status-flag register: masked ALU update, direct write and context stack.
module flags_ctx_register
    import flags_pkg::*;
#(
    parameter int unsigned NFLAGS = 4,
    parameter int unsigned OP_W   = 5,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              upd_en_i,
    input  logic [OP_W-1:0]   op_i,
    input  logic [NFLAGS-1:0] flags_in_i,
    input  logic              wr_en_i,
    input  logic [NFLAGS-1:0] wr_data_i,
    input  logic              push_i,
    input  logic              pop_i,
    output logic [NFLAGS-1:0] flags_out_o,
    output logic [CNT_W-1:0]  depth_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              err_o
);

    logic [NFLAGS-1:0] flags_q, flags_d;
    logic [NFLAGS-1:0] mask;
    logic [NFLAGS-1:0] stack_top;
    logic              pop_ok;
    logic [31:0]       op_ext;

    // Opcodes with any bit above the 5-bit table update nothing.
    assign op_ext = 32'(op_i);
    assign mask   = (op_ext[31:5] == '0) ? NFLAGS'(flag_mask(op_ext[4:0])) : '0;

    flags_ctx_stack #(
        .NFLAGS (NFLAGS),
        .DEPTH  (DEPTH)
    ) u_stack (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .push_i   (push_i),
        .pop_i    (pop_i),
        .wdata_i  (flags_q),
        .rdata_o  (stack_top),
        .pop_ok_o (pop_ok),
        .depth_o  (depth_o),
        .full_o   (full_o),
        .empty_o  (empty_o),
        .err_o    (err_o)
    );

    // pop > wr_en > upd_en; losers are dropped.
    always_comb begin
        flags_d = flags_q;
        if (pop_ok) begin
            flags_d = stack_top;
        end else if (wr_en_i) begin
            flags_d = wr_data_i;
        end else if (upd_en_i) begin
            flags_d = (flags_q & ~mask) | (flags_in_i & mask);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags_out_o = flags_q;

endmodule

// File: tb/tb_flags_ctx_register.sv
// Randomised and directed bench for flags_ctx_register against a queue-based model.
module tb_flags_ctx_register;

    logic       clk = 1'b0;
    logic       reset;
    logic       upd_en, wr_en, push, pop;
    logic [4:0] op;
    logic [3:0] flags_in, wr_data;
    logic [3:0] flags_out;
    logic [2:0] depth;
    logic       full, empty, err;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    logic [3:0] m_flags;
    logic [3:0] m_stack[$];
    logic       m_err;

    always #5 clk = ~clk;

    flags_ctx_register #(
        .NFLAGS (4),
        .OP_W   (5),
        .DEPTH  (4)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .upd_en_i    (upd_en),
        .op_i        (op),
        .flags_in_i  (flags_in),
        .wr_en_i     (wr_en),
        .wr_data_i   (wr_data),
        .push_i      (push),
        .pop_i       (pop),
        .flags_out_o (flags_out),
        .depth_o     (depth),
        .full_o      (full),
        .empty_o     (empty),
        .err_o       (err)
    );

    function automatic logic [3:0] ref_mask(input int o);
        if (o == 0 || o == 1 || (o >= 3 && o <= 6)) return 4'b1111;
        if (o == 8 || o == 9) return 4'b0111;
        if (o == 16) return 4'b0001;
        if (o >= 17 && o <= 30) return 4'b0101;
        return 4'b0000;
    endfunction

    task automatic model_apply(input logic pu, po, we, input logic [3:0] wd,
                               input logic ue, input logic [4:0] o, input logic [3:0] fi);
        logic [3:0] nf;
        logic [3:0] msk;
        logic [3:0] top;
        nf = m_flags;
        msk = ref_mask(int'(o));
        if (ue) nf = (m_flags & ~msk) | (fi & msk);
        if (we) nf = wd;
        if (pu && po) begin
            if (m_stack.size() > 0) begin
                top = m_stack[m_stack.size() - 1];
                m_stack[m_stack.size() - 1] = m_flags;
                nf = top;
            end else m_err = 1'b1;
        end else if (pu) begin
            if (m_stack.size() < 4) m_stack.push_back(m_flags);
            else m_err = 1'b1;
        end else if (po) begin
            if (m_stack.size() > 0) nf = m_stack.pop_back();
            else m_err = 1'b1;
        end
        m_flags = nf;
    endtask

    task automatic drive(input logic pu, po, we, input logic [3:0] wd,
                         input logic ue, input logic [4:0] o, input logic [3:0] fi);
        @(negedge clk);
        push = pu; pop = po; wr_en = we; wr_data = wd;
        upd_en = ue; op = o; flags_in = fi;
        model_apply(pu, po, we, wd, ue, o, fi);
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; wr_en = 1'b0; upd_en = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        push = 0; pop = 0; wr_en = 0; upd_en = 0; op = 0; flags_in = 0; wr_data = 0;
        m_flags = 4'b0; m_stack.delete(); m_err = 1'b0;
        #12;
        n_total++; if (flags_out !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", flags_out); else n_pass++;
        n_total++; if (depth !== 3'd0) $display("FAIL reset_depth: got %0d want 0", depth); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_masks;
        logic [4:0] ops [5];
        logic [3:0] exp [5];
        ops = '{5'b10000, 5'b10010, 5'b01000, 5'b00011, 5'b00111};
        exp = '{4'b0001, 4'b0101, 4'b0111, 4'b1111, 4'b1111};
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 4'b0, 1'b1, ops[i], 4'b1111);
            n_total++;
            if (flags_out !== exp[i] || flags_out !== m_flags)
                $display("FAIL mask_op%b: got %b want %b", ops[i], flags_out, exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_priority;
        drive(1'b0, 1'b0, 1'b1, 4'b1010, 1'b0, 5'b0, 4'b0);
        drive(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 5'b0, 4'b0);
        drive(1'b0, 1'b1, 1'b1, 4'b0110, 1'b1, 5'b00000, 4'b1111);
        n_total++; if (flags_out !== 4'b1010) $display("FAIL prio_flags: got %b want 1010", flags_out); else n_pass++;
        n_total++; if (depth !== 3'd0) $display("FAIL prio_depth: got %0d want 0", depth); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL prio_err: got %b want 0", err); else n_pass++;
    endtask

    task automatic test_swap;
        drive(1'b0, 1'b0, 1'b1, 4'b0011, 1'b0, 5'b0, 4'b0);
        drive(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 5'b0, 4'b0);
        drive(1'b0, 1'b0, 1'b1, 4'b1100, 1'b0, 5'b0, 4'b0);
        drive(1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 5'b0, 4'b0);
        n_total++; if (flags_out !== 4'b0011) $display("FAIL swap_flags: got %b want 0011", flags_out); else n_pass++;
        n_total++; if (depth !== 3'd1) $display("FAIL swap_depth: got %0d want 1", depth); else n_pass++;
        drive(1'b0, 1'b1, 1'b0, 4'b0, 1'b0, 5'b0, 4'b0);
        n_total++; if (flags_out !== 4'b1100) $display("FAIL swap_top: got %b want 1100", flags_out); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL swap_err: got %b want 0", err); else n_pass++;
    endtask

    task automatic test_push_update;
        drive(1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 5'b0, 4'b0);
        drive(1'b1, 1'b0, 1'b0, 4'b0, 1'b1, 5'b00000, 4'b1110);
        n_total++; if (flags_out !== 4'b1110) $display("FAIL pushupd_flags: got %b want 1110", flags_out); else n_pass++;
        n_total++; if (depth !== 3'd1) $display("FAIL pushupd_depth: got %0d want 1", depth); else n_pass++;
        drive(1'b0, 1'b1, 1'b0, 4'b0, 1'b0, 5'b0, 4'b0);
        n_total++; if (flags_out !== 4'b0001) $display("FAIL pushupd_top: got %b want 0001", flags_out); else n_pass++;
    endtask

    task automatic test_fill_drain;
        logic [3:0] vals [4];
        logic [3:0] outs [4];
        vals = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        outs = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, vals[i], 1'b0, 5'b0, 4'b0);
            drive(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 5'b0, 4'b0);
        end
        n_total++; if (full !== 1'b1) $display("FAIL fill_full: got %b want 1", full); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL fill_err_clean: got %b want 0", err); else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 5'b0, 4'b0);
        n_total++; if (err !== 1'b1) $display("FAIL overflow_err: got %b want 1", err); else n_pass++;
        n_total++; if (depth !== 3'd4) $display("FAIL overflow_depth: got %0d want 4", depth); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 4'b0, 1'b0, 5'b0, 4'b0);
            n_total++;
            if (flags_out !== outs[i]) $display("FAIL drain_%0d: got %b want %b", i, flags_out, outs[i]);
            else n_pass++;
        end
        n_total++; if (empty !== 1'b1) $display("FAIL drain_empty: got %b want 1", empty); else n_pass++;
        drive(1'b0, 1'b1, 1'b0, 4'b0, 1'b0, 5'b0, 4'b0);
        n_total++; if (flags_out !== 4'b0001) $display("FAIL underflow_hold: got %b want 0001", flags_out); else n_pass++;
        n_total++; if (depth !== 3'd0) $display("FAIL underflow_depth: got %0d want 0", depth); else n_pass++;
    endtask

    task automatic test_random;
        logic pu, po, we, ue;
        for (int i = 0; i < 300; i++) begin
            pu = ($urandom_range(0, 2) == 0);
            po = ($urandom_range(0, 2) == 0);
            we = ($urandom_range(0, 3) == 0);
            ue = ($urandom_range(0, 1) == 0);
            drive(pu, po, we, 4'($urandom), ue, 5'($urandom), 4'($urandom));
            n_total++; if (flags_out !== m_flags) $display("FAIL rnd_flags@%0d: got %b want %b", i, flags_out, m_flags); else n_pass++;
            n_total++; if (depth !== 3'(m_stack.size())) $display("FAIL rnd_depth@%0d: got %0d want %0d", i, depth, m_stack.size()); else n_pass++;
            n_total++; if (full !== (m_stack.size() == 4)) $display("FAIL rnd_full@%0d: got %b", i, full); else n_pass++;
            n_total++; if (empty !== (m_stack.size() == 0)) $display("FAIL rnd_empty@%0d: got %b", i, empty); else n_pass++;
            n_total++; if (err !== m_err) $display("FAIL rnd_err@%0d: got %b want %b", i, err, m_err); else n_pass++;
        end
    endtask

    task automatic test_reset_midrun;
        while (m_stack.size() > 0) drive(1'b0, 1'b1, 1'b0, 4'b0, 1'b0, 5'b0, 4'b0);
        drive(1'b0, 1'b1, 1'b0, 4'b0, 1'b0, 5'b0, 4'b0);
        drive(1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 5'b0, 4'b0);
        drive(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 5'b0, 4'b0);
        drive(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 5'b0, 4'b0);
        n_total++;
        if (flags_out !== 4'b1111 || depth !== 3'd2 || err !== 1'b1)
            $display("FAIL midrun_setup: flags=%b depth=%0d err=%b want 1111/2/1", flags_out, depth, err);
        else n_pass++;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_total++; if (flags_out !== 4'b0000) $display("FAIL midrun_flags: got %b want 0000", flags_out); else n_pass++;
        n_total++; if (depth !== 3'd0) $display("FAIL midrun_depth: got %0d want 0", depth); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL midrun_err: got %b want 0", err); else n_pass++;
        n_total++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL midrun_empty_full: got %b/%b want 1/0", empty, full); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        m_flags = 4'b0; m_stack.delete(); m_err = 1'b0;
    endtask

    initial begin
        test_reset();
        test_masks();
        test_priority();
        test_swap();
        test_push_update();
        test_fill_drain();
        test_random();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
